instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction written.
- DEPTH, 64, maximum number of instruction words per program.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, reset: synchronous, active-high.
- clear, in, 1, return to IDLE and restart the program at BASE_ADDR.
- req_valid, in, 1, instruction request present.
- req_ready, out, 1, encoder can accept a request.
- req_op, in, 4, operation selector: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 LW, 7 SW, 8 ADDI; 9-15 are illegal.
- req_rs / req_rt / req_rd, in, 5 each, register fields.
- req_imm, in, 16, immediate field.
- req_last, in, 1, marks the final instruction of the program.
- mem_we, out, 1, instruction-memory write strobe.
- mem_addr, out, 32, byte address of the write.
- mem_wdata, out, 32, encoded instruction word.
- count, out, $clog2(DEPTH)+1, number of words written so far.
- done, out, 1, program complete.
- err, out, 1, illegal op received.

Function
REQ-003 The FSM SHALL have four states: IDLE, WRITE, DONE, ERROR.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-005 IDLE, on accept with a legal op: SHALL register the encoded word and go to WRITE.
REQ-006 IDLE, on accept with an illegal op: SHALL go to ERROR; no write occurs.
REQ-007 mem_we SHALL be registered and SHALL be 1 for exactly one cycle (the WRITE cycle), which is the cycle after acceptance. In that cycle:
- mem_addr = BASE_ADDR + 4*count (pre-increment value).
- mem_wdata = the encoded word.
REQ-008 WRITE SHALL increment count and then transition:
- to DONE if req_last was set on the accepted request, or if count+1 == DEPTH;
- otherwise to IDLE.
Throughput is therefore one word per 2 cycles.
REQ-009 R-type ops (0-5) SHALL encode as {6'h00, rs, rt, rd, 5'b0, funct}, with funct = 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR; req_imm is ignored.
REQ-010 I-type ops SHALL encode as {opcode, rs, rt, imm}, with opcode = 0x23 LW, 0x2B SW, 0x08 ADDI; req_rd is ignored.
REQ-011 done SHALL be 1 only in DONE; err SHALL be 1 only in ERROR. Both states hold, with req_ready = 0, until clear or rst.
REQ-012 clear SHALL set count to 0 and next state to IDLE from any state. A write already in its WRITE cycle completes unchanged. clear takes priority over a simultaneous accept, which is ignored.
REQ-013 mem_addr SHALL use 32-bit wrap-around arithmetic; count never exceeds DEPTH.
REQ-014 Outside the WRITE cycle, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold their last values.

Reset
REQ-015 When rst = 1 at a clock edge, the next state SHALL be:
- state = IDLE, count = 0;
- mem_we = 0, mem_addr = 0, mem_wdata = 0;
- done = 0, err = 0;
- req_ready = 1 from the first cycle after reset.
REQ-016 rst SHALL override clear and any handshake. rst asserted during WRITE cancels the increment; the strobe already in that cycle is not repeated.

Structure
REQ-017 The opcode/funct constants and the req_op enumeration SHALL live in shared package instr_pkg, used by both this block and the decoder.
REQ-018 Field packing SHALL be a combinational sub-module, instr_word_fmt (inputs: op, rs, rt, rd, imm; outputs: word, illegal). The FSM, counter and output registers live in instr_encoder.

Verification
REQ-019 ADD rs=1 rt=2 rd=3 -> one-cycle mem_we, mem_addr=0x00000000, mem_wdata=0x00221820, count=1.
REQ-020 LW rs=29 rt=8 imm=0x0004, then SW rs=29 rt=9 imm=0xFFFC with req_last=1 -> writes 0x8FA80004 @0x0 and 0xAFA9FFFC @0x4; done=1; req_ready=0.
REQ-021 DEPTH=4, four ADDI rs=0 rt=1 imm=5 back-to-back, no last -> 0x20010005 written at 0x0, 0x4, 0x8, 0xC; done after the 4th write; a 5th req_valid is not accepted.
REQ-022 req_op=4'hA -> err=1, no mem_we, req_ready=0; then clear -> IDLE, count=0; next NOR rs=4 rt=5 rd=6 writes 0x00853027 @BASE_ADDR.
REQ-023 rst pulsed during the WRITE cycle of the 2nd word -> next cycle count=0, mem_we=0, req_ready=1; the next write goes to BASE_ADDR.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared opcode/funct constants and the request op enumeration
// for the instruction encoder and decoder.
package instr_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_ADDI = 4'd8
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/instr_word_fmt.sv
// Combinational field packer: turns a request op and its fields
// into a 32-bit instruction word, flagging unknown ops.
import instr_pkg::*;

module instr_word_fmt (
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic       is_r;
    logic [5:0] funct;
    logic [5:0] opc;

    // Decode op into either an R-type funct or an I-type opcode
    always_comb begin
        is_r    = 1'b0;
        funct   = 6'h00;
        opc     = OPC_RTYPE;
        illegal = 1'b0;
        word    = 32'h0;
        unique case (1'b1)
            (op == OP_ADD):  begin is_r = 1'b1; funct = FN_ADD; end
            (op == OP_SUB):  begin is_r = 1'b1; funct = FN_SUB; end
            (op == OP_AND):  begin is_r = 1'b1; funct = FN_AND; end
            (op == OP_OR):   begin is_r = 1'b1; funct = FN_OR;  end
            (op == OP_XOR):  begin is_r = 1'b1; funct = FN_XOR; end
            (op == OP_NOR):  begin is_r = 1'b1; funct = FN_NOR; end
            (op == OP_LW):   opc = OPC_LW;
            (op == OP_SW):   opc = OPC_SW;
            (op == OP_ADDI): opc = OPC_ADDI;
            default:         illegal = 1'b1;
        endcase
        if (illegal)
            word = 32'h0;
        else if (is_r)
            word = {OPC_RTYPE, rs, rt, rd, 5'b0, funct};
        else
            word = {opc, rs, rt, imm};
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts op requests, packs them and writes
// one word every two cycles into instruction memory.
import instr_pkg::*;

module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_op,
    input  logic [4:0]                 req_rs,
    input  logic [4:0]                 req_rt,
    input  logic [4:0]                 req_rd,
    input  logic [15:0]                req_imm,
    input  logic                       req_last,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       done,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    state_e      state;
    logic        last_q;
    logic [31:0] word;
    logic        illegal;
    logic [31:0] offset;

    instr_word_fmt u_fmt (
        .op      (req_op),
        .rs      (req_rs),
        .rt      (req_rt),
        .rd      (req_rd),
        .imm     (req_imm),
        .word    (word),
        .illegal (illegal)
    );

    assign offset    = 32'(count) << 2;
    assign req_ready = (state == ST_IDLE);
    assign done      = (state == ST_DONE);
    assign err       = (state == ST_ERROR);

    // Program FSM with the write strobe, address/data and word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            last_q    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            mem_we <= 1'b0;
            if (clear) begin
                state <= ST_IDLE;
                count <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (req_valid) begin
                            if (illegal) begin
                                state <= ST_ERROR;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= BASE_ADDR + offset;
                                mem_wdata <= word;
                                last_q    <= req_last;
                                state     <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        count <= count + 1'b1;
                        if (last_q || count == LAST_IDX)
                            state <= ST_DONE;
                        else
                            state <= ST_IDLE;
                    end
                    ST_DONE:  state <= ST_DONE;
                    ST_ERROR: state <= ST_ERROR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: default instance plus a
// DEPTH=4 instance whose base address wraps past 2^32.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [4:0]  req_rs = 5'd0;
    logic [4:0]  req_rt = 5'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [15:0] req_imm = 16'd0;
    logic        req_last = 1'b0;

    logic        a_ready, a_we, a_done, a_err;
    logic [31:0] a_addr, a_data;
    logic [6:0]  a_count;
    logic        b_ready, b_we, b_done, b_err;
    logic [31:0] b_addr, b_data;
    logic [2:0]  b_count;

    localparam logic [31:0] B_BASE = 32'hFFFF_FFF8;

    int checks = 0;
    int failures = 0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(64)) dut_a (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(a_valid), .req_ready(a_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .req_rd(req_rd), .req_imm(req_imm), .req_last(req_last),
        .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_data),
        .count(a_count), .done(a_done), .err(a_err)
    );

    instr_encoder #(.BASE_ADDR(B_BASE), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .clear(clear),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .req_rd(req_rd), .req_imm(req_imm), .req_last(req_last),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_data),
        .count(b_count), .done(b_done), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op,
            input logic [4:0] rs, input logic [4:0] rt,
            input logic [4:0] rd, input logic [15:0] imm);
        case (op)
            4'd0: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2: return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd3: return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd4: return {6'h00, rs, rt, rd, 5'd0, 6'h26};
            4'd5: return {6'h00, rs, rt, rd, 5'd0, 6'h27};
            4'd6: return {6'h23, rs, rt, imm};
            4'd7: return {6'h2B, rs, rt, imm};
            4'd8: return {6'h08, rs, rt, imm};
            default: return 32'h0;
        endcase
    endfunction

    // Scoreboard: every strobe must match the oldest expected write
    always @(negedge clk) begin
        logic [63:0] e;
        if (a_we === 1'b1) begin
            check("a_we_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_addr", a_addr, e[63:32]);
                check("a_data", a_data, e[31:0]);
            end
        end
        if (b_we === 1'b1) begin
            check("b_we_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_addr", b_addr, e[63:32]);
                check("b_data", b_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, presents one request for one accepting edge.
    // Returns #1 after that edge, i.e. inside the WRITE cycle.
    task automatic send(input bit sel, input logic [3:0] op,
            input logic [4:0] rs, input logic [4:0] rt,
            input logic [4:0] rd, input logic [15:0] imm,
            input logic last, input bit legal,
            input logic [31:0] addr, input logic [31:0] word);
        int n = 0;
        while (!(sel ? b_ready : a_ready) && n < 20) begin
            tick();
            n++;
        end
        check(sel ? "b_ready_wait" : "a_ready_wait",
              32'(sel ? b_ready : a_ready), 32'd1);
        req_op = op; req_rs = rs; req_rt = rt;
        req_rd = rd; req_imm = imm; req_last = last;
        if (legal) begin
            if (sel) qb.push_back({addr, word});
            else     qa.push_back({addr, word});
        end
        if (sel) b_valid = 1'b1;
        else     a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        req_last = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;

        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_we", 32'(a_we), 32'd0);
        check("rst_addr", a_addr, 32'h0);
        check("rst_data", a_data, 32'h0);
        check("rst_count", 32'(a_count), 32'd0);
        check("rst_done_err", {30'd0, a_done, a_err}, 32'd0);

        send(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 1'b1,
             32'h0, 32'h0022_1820);
        tick();
        check("add_count", 32'(a_count), 32'd1);
        check("add_we_once", 32'(a_we), 32'd0);
        check("add_ready", 32'(a_ready), 32'd1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count", 32'(a_count), 32'd0);

        send(0, 4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 1'b0, 1'b1,
             32'h0, 32'h8FA8_0004);
        send(0, 4'd7, 5'd29, 5'd9, 5'd0, 16'hFFFC, 1'b1, 1'b1,
             32'h4, 32'hAFA9_FFFC);
        tick();
        check("last_done", 32'(a_done), 32'd1);
        check("last_ready", 32'(a_ready), 32'd0);
        check("last_count", 32'(a_count), 32'd2);
        a_valid = 1'b1;
        repeat (3) tick();
        a_valid = 1'b0;
        check("done_hold", 32'(a_done), 32'd1);
        check("done_addr_hold", a_addr, 32'h4);
        check("done_data_hold", a_data, 32'hAFA9_FFFC);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("done_clr", {31'd0, a_done}, 32'd0);
        send(0, 4'hA, 5'd1, 5'd1, 5'd1, 16'h1, 1'b0, 1'b0,
             32'h0, 32'h0);
        tick();
        check("ill_err", 32'(a_err), 32'd1);
        check("ill_ready", 32'(a_ready), 32'd0);
        check("ill_count", 32'(a_count), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("ill_clr_err", 32'(a_err), 32'd0);
        check("ill_clr_ready", 32'(a_ready), 32'd1);
        send(0, 4'd5, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0, 1'b1,
             32'h0, 32'h0085_3027);
        tick();
        check("nor_count", 32'(a_count), 32'd1);

        req_op = 4'd0;
        a_valid = 1'b1;
        clear = 1'b1;
        tick();
        a_valid = 1'b0;
        clear = 1'b0;
        check("clr_prio_count", 32'(a_count), 32'd0);
        check("clr_prio_ready", 32'(a_ready), 32'd1);

        send(0, 4'd0, 5'd7, 5'd8, 5'd9, 16'h0, 1'b0, 1'b1,
             32'h0, enc(4'd0, 5'd7, 5'd8, 5'd9, 16'h0));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_wr_count", 32'(a_count), 32'd0);
        check("clr_wr_ready", 32'(a_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            op  = 4'($urandom_range(0, 8));
            rs  = 5'($urandom);
            rt  = 5'($urandom);
            rd  = 5'($urandom);
            imm = 16'($urandom);
            send(0, op, rs, rt, rd, imm, 1'b0, 1'b1,
                 32'(i * 4), enc(op, rs, rt, rd, imm));
        end
        tick();
        check("rand_count", 32'(a_count), 32'd8);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(0, 4'd1, 5'd2, 5'd3, 5'd4, 16'h0, 1'b0, 1'b1,
             32'h0, 32'h0043_2022);
        send(0, 4'd2, 5'd5, 5'd6, 5'd7, 16'h0, 1'b0, 1'b1,
             32'h4, 32'h00A6_3824);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_count", 32'(a_count), 32'd0);
        check("rstw_we", 32'(a_we), 32'd0);
        check("rstw_ready", 32'(a_ready), 32'd1);
        send(0, 4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0, 1'b1,
             32'h0, 32'h0021_0825);
        tick();

        for (int i = 0; i < 4; i++)
            send(1, 4'd8, 5'd0, 5'd1, 5'd0, 16'h0005, 1'b0, 1'b1,
                 B_BASE + 32'(i * 4), 32'h2001_0005);
        tick();
        check("b_done", 32'(b_done), 32'd1);
        check("b_count", 32'(b_count), 32'd4);
        check("b_ready", 32'(b_ready), 32'd0);
        b_valid = 1'b1;
        repeat (3) tick();
        b_valid = 1'b0;
        check("b_done_hold", 32'(b_done), 32'd1);
        check("b_count_hold", 32'(b_count), 32'd4);

        repeat (2) tick();
        check("a_queue_empty", 32'(qa.size()), 32'd0);
        check("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
